mips_dmem_arbiter: RTL and testbench

//   Shares the single-port data memory of the pipelined MIPS between the MEM

---
 rtl/mips_dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_mips_dmem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// mips_dmem_arbiter: round-robin CPU/debug arbiter for the single-port data RAM
// Revision: 1.0
// ------------------------------------------------------------------------
module mips_dmem_arbiter #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_done,
  output logic              o_cpu_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_dbg_ack,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic C_OWN_CPU = 1'b0;
  localparam logic C_OWN_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_grant;
  logic              w_grant_own;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              w_access;
  logic              w_last;

  assign w_access = (r_state == ST_ACCESS);
  assign w_last   = w_access && (r_cnt == C_CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_own = C_OWN_CPU;
    case (r_state)
      ST_IDLE: begin
        if (i_cpu_req || i_dbg_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ACCESS;
          // On a tie the port that was not served last wins.
          if (i_cpu_req && i_dbg_req) w_grant_own = ~r_last_grant;
          else                        w_grant_own = i_dbg_req ? C_OWN_DBG : C_OWN_CPU;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == C_CNT_LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= C_OWN_DBG;
      r_owner      <= C_OWN_CPU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner      <= w_grant_own;
        r_last_grant <= w_grant_own;
        r_cnt        <= '0;
        r_we         <= (w_grant_own == C_OWN_DBG) ? i_dbg_we    : i_cpu_we;
        r_addr       <= (w_grant_own == C_OWN_DBG) ? i_dbg_addr  : i_cpu_addr;
        r_wdata      <= (w_grant_own == C_OWN_DBG) ? i_dbg_wdata : i_cpu_wdata;
      end else if (w_access) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last && !r_we) begin
        if (r_owner == C_OWN_CPU) r_cpu_rdata <= i_mem_rdata;
        else                      r_dbg_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_mem_we    = w_access && r_we && (r_cnt == '0);
  assign o_mem_addr  = w_access ? r_addr  : '0;
  assign o_mem_wdata = w_access ? r_wdata : '0;
  assign o_cpu_done  = (r_state == ST_DONE) && (r_owner == C_OWN_CPU);
  assign o_dbg_ack   = (r_state == ST_DONE) && (r_owner == C_OWN_DBG);
  assign o_cpu_stall = i_cpu_req & ~o_cpu_done;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_dbg_rdata = r_dbg_rdata;
  assign o_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mips_dmem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_mips_dmem_arbiter: directed vectors for the data-memory arbiter
// Revision: 1.0
// ------------------------------------------------------------------------
module tb_mips_dmem_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NV = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: WAIT_CYCLES=1, instance b: WAIT_CYCLES=3
  logic          a_rst, a_creq, a_cwe, a_dreq, a_dwe;
  logic [AW-1:0] a_caddr, a_daddr, a_mem_addr;
  logic [DW-1:0] a_cwd, a_dwd, a_crd, a_drd, a_mem_wdata, a_mem_rdata;
  logic          a_done, a_stall, a_ack, a_mem_we, a_busy;

  logic          b_rst, b_creq, b_cwe, b_dreq, b_dwe;
  logic [AW-1:0] b_caddr, b_daddr, b_mem_addr;
  logic [DW-1:0] b_cwd, b_dwd, b_crd, b_drd, b_mem_wdata, b_mem_rdata;
  logic          b_done, b_stall, b_ack, b_mem_we, b_busy;

  mips_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_dut_a (
    .i_clk(clk), .i_rst(a_rst),
    .i_cpu_req(a_creq), .i_cpu_we(a_cwe), .i_cpu_addr(a_caddr), .i_cpu_wdata(a_cwd),
    .o_cpu_rdata(a_crd), .o_cpu_done(a_done), .o_cpu_stall(a_stall),
    .i_dbg_req(a_dreq), .i_dbg_we(a_dwe), .i_dbg_addr(a_daddr), .i_dbg_wdata(a_dwd),
    .o_dbg_rdata(a_drd), .o_dbg_ack(a_ack),
    .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
    .i_mem_rdata(a_mem_rdata), .o_busy(a_busy)
  );

  mips_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst),
    .i_cpu_req(b_creq), .i_cpu_we(b_cwe), .i_cpu_addr(b_caddr), .i_cpu_wdata(b_cwd),
    .o_cpu_rdata(b_crd), .o_cpu_done(b_done), .o_cpu_stall(b_stall),
    .i_dbg_req(b_dreq), .i_dbg_we(b_dwe), .i_dbg_addr(b_daddr), .i_dbg_wdata(b_dwd),
    .o_dbg_rdata(b_drd), .o_dbg_ack(b_ack),
    .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .i_mem_rdata(b_mem_rdata), .o_busy(b_busy)
  );

  // RAM models: asynchronous read, write on the clock edge; word i preset to 0x1000_0000+i
  logic          ram_init;
  logic [DW-1:0] ram_a [32];
  logic [DW-1:0] ram_b [32];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) begin
        ram_a[i] <= 32'h1000_0000 + 32'(i);
        ram_b[i] <= 32'h1000_0000 + 32'(i);
      end
    end else begin
      if (a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
      if (b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
    end
  end

  assign a_mem_rdata = ram_a[a_mem_addr];
  assign b_mem_rdata = ram_b[b_mem_addr];

  typedef struct {
    logic          rst, creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          dreq, dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwd;
    logic          done, stall, ack, mwe, busy;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd, crd, drd;
  } vec_t;

  vec_t vecs [NV];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(
    input logic rst, creq, cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
    input logic dreq, dwe, input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
    input logic done, stall, ack, mwe, busy, input logic [AW-1:0] maddr,
    input logic [DW-1:0] mwd, crd, drd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.done = done; v.stall = stall; v.ack = ack; v.mwe = mwe; v.busy = busy;
    v.maddr = maddr; v.mwd = mwd; v.crd = crd; v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] D  = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] P  = 32'h1234_5678;
  localparam logic [DW-1:0] M4 = 32'h1000_0004;
  localparam logic [DW-1:0] CF = 32'hCAFE_F00D;

  initial begin
    ram_init = 1'b1;
    a_rst = 1'b1; a_creq = 0; a_cwe = 0; a_caddr = '0; a_cwd = '0;
    a_dreq = 0; a_dwe = 0; a_daddr = '0; a_dwd = '0;
    b_rst = 1'b1; b_creq = 0; b_cwe = 0; b_caddr = '0; b_cwd = '0;
    b_dreq = 0; b_dwe = 0; b_daddr = '0; b_dwd = '0;

    //               rst cr cw ca cwd dr dw da dwd | dn st ak we by ma mwd crd drd
    vecs[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0,  0, 0, 0);
    // CPU store 0xDEADBEEF to word 3
    vecs[1]  = mk(0, 1, 1, 3,  D, 0, 0, 0,  0,   0, 1, 0, 0, 0, 0,  0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 3,  D, 0, 0, 0,  0,   0, 1, 0, 1, 1, 3,  D, 0, 0);
    vecs[3]  = mk(0, 1, 1, 3,  D, 0, 0, 0,  0,   1, 0, 0, 0, 1, 0,  0, 0, 0);
    // CPU load word 3
    vecs[4]  = mk(0, 1, 0, 3,  0, 0, 0, 0,  0,   0, 1, 0, 0, 0, 0,  0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 3,  0, 0, 0, 0,  0,   0, 1, 0, 0, 1, 3,  0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 3,  0, 0, 0, 0,  0,   1, 0, 0, 0, 1, 0,  0, D, 0);
    // reset, then simultaneous requests held high: CPU, DBG, CPU
    vecs[7]  = mk(1, 0, 0, 0,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0,  0, D, 0);
    vecs[8]  = mk(0, 1, 0, 3,  0, 1, 0, 4,  0,   0, 1, 0, 0, 0, 0,  0, 0, 0);
    vecs[9]  = mk(0, 1, 0, 3,  0, 1, 0, 4,  0,   0, 1, 0, 0, 1, 3,  0, 0, 0);
    vecs[10] = mk(0, 1, 0, 3,  0, 1, 0, 4,  0,   1, 0, 0, 0, 1, 0,  0, D, 0);
    vecs[11] = mk(0, 1, 0, 3,  0, 1, 0, 4,  0,   0, 1, 0, 0, 0, 0,  0, D, 0);
    vecs[12] = mk(0, 1, 0, 3,  0, 1, 0, 4,  0,   0, 1, 0, 0, 1, 4,  0, D, 0);
    vecs[13] = mk(0, 1, 0, 3,  0, 1, 0, 4,  0,   0, 1, 1, 0, 1, 0,  0, D, M4);
    vecs[14] = mk(0, 1, 0, 3,  0, 1, 0, 4,  0,   0, 1, 0, 0, 0, 0,  0, D, M4);
    vecs[15] = mk(0, 1, 0, 3,  0, 1, 0, 4,  0,   0, 1, 0, 0, 1, 3,  0, D, M4);
    vecs[16] = mk(0, 1, 0, 3,  0, 0, 0, 0,  0,   1, 0, 0, 0, 1, 0,  0, D, M4);
    // debug write 0x12345678 to word 31, then read it back
    vecs[17] = mk(0, 0, 0, 0,  0, 1, 1, 31, P,   0, 0, 0, 0, 0, 0,  0, D, M4);
    vecs[18] = mk(0, 0, 0, 0,  0, 1, 1, 31, P,   0, 0, 0, 1, 1, 31, P, D, M4);
    vecs[19] = mk(0, 0, 0, 0,  0, 1, 1, 31, P,   0, 0, 1, 0, 1, 0,  0, D, M4);
    vecs[20] = mk(0, 0, 0, 0,  0, 1, 0, 31, 0,   0, 0, 0, 0, 0, 0,  0, D, M4);
    vecs[21] = mk(0, 0, 0, 0,  0, 1, 0, 31, 0,   0, 0, 0, 0, 1, 31, 0, D, M4);
    vecs[22] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0,   0, 0, 1, 0, 1, 0,  0, D, P);
    vecs[23] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0,  0, D, P);

    repeat (2) @(posedge clk);
    #1 ram_init = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      a_rst = vecs[i].rst;   a_creq = vecs[i].creq; a_cwe = vecs[i].cwe;
      a_caddr = vecs[i].caddr; a_cwd = vecs[i].cwd;
      a_dreq = vecs[i].dreq; a_dwe = vecs[i].dwe;
      a_daddr = vecs[i].daddr; a_dwd = vecs[i].dwd;
      @(negedge clk);
      chk("cpu_done",  i, a_done,      vecs[i].done);
      chk("cpu_stall", i, a_stall,     vecs[i].stall);
      chk("dbg_ack",   i, a_ack,       vecs[i].ack);
      chk("mem_we",    i, a_mem_we,    vecs[i].mwe);
      chk("busy",      i, a_busy,      vecs[i].busy);
      chk("mem_addr",  i, a_mem_addr,  vecs[i].maddr);
      chk("mem_wdata", i, a_mem_wdata, vecs[i].mwd);
      chk("cpu_rdata", i, a_crd,       vecs[i].crd);
      chk("dbg_rdata", i, a_drd,       vecs[i].drd);
    end

    // WAIT_CYCLES=3: reset in the middle of a CPU write
    tick;
    b_rst = 1'b0; b_creq = 1; b_cwe = 1; b_caddr = 9; b_cwd = CF;
    #1 chk("t5_idle_busy", 0, b_busy, 0);
    tick;
    chk("t5_we_first", 0, b_mem_we, 1);
    chk("t5_busy", 0, b_busy, 1);
    tick;
    chk("t5_we_second", 0, b_mem_we, 0);
    chk("t5_addr", 0, b_mem_addr, 9);
    b_rst = 1'b1;
    tick;
    b_rst = 1'b0; b_creq = 0;
    #1;
    chk("t5_rst_busy", 0, b_busy, 0);
    chk("t5_rst_we", 0, b_mem_we, 0);
    chk("t5_rst_done", 0, b_done, 0);
    chk("t5_rst_addr", 0, b_mem_addr, 0);
    tick;
    chk("t5_no_done", 0, b_done, 0);
    chk("t5_no_ack", 0, b_ack, 0);
    // Both request; CPU must win because reset restored the tie-break
    b_creq = 1; b_cwe = 0; b_caddr = 9; b_cwd = '0;
    b_dreq = 1; b_dwe = 0; b_daddr = 5;
    #1 chk("t5_stall", 0, b_stall, 1);
    tick;
    chk("t5_cpu_first", 0, b_mem_addr, 9);
    chk("t6_acc_stall", 0, b_stall, 1);
    // CPU drops its request mid-access; the load still completes once
    tick;
    b_creq = 0;
    #1 chk("t6_done", 1, b_done, 0);
    tick;
    chk("t6_done", 2, b_done, 0);
    chk("t6_busy", 2, b_busy, 1);
    tick;
    chk("t6_done", 3, b_done, 1);
    chk("t6_rdata", 3, b_crd, CF);
    chk("t6_stall", 3, b_stall, 0);
    tick;
    chk("t6_done", 4, b_done, 0);
    chk("t6_idle", 4, b_busy, 0);
    tick;
    chk("t6_dbg_addr", 0, b_mem_addr, 5);
    tick;
    tick;
    chk("t6_dbg_ack_early", 0, b_ack, 0);
    tick;
    chk("t6_dbg_ack", 0, b_ack, 1);
    chk("t6_dbg_rdata", 0, b_drd, 32'h1000_0005);
    chk("t6_cpu_hold", 0, b_crd, CF);
    b_dreq = 0;
    tick;
    chk("t6_end_busy", 0, b_busy, 0);
    chk("t6_end_done", 0, b_done, 0);
    chk("t6_end_ack", 0, b_ack, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
